// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: owner tag types shared by the arbiter and its response-order FIFO
package mem_port_arbiter_pkg;
  typedef enum logic {ARB_OWN_I, ARB_OWN_D} arb_owner_e;
  typedef struct packed {
    arb_owner_e owner;
    logic       kill;
  } arb_tag_s;
endpackage

// File: rtl/mem_port_arbiter_tag_fifo.sv
// mem_port_arbiter_tag_fifo: in-order owner tags for accepted memory requests, with fetch kill-all
module mem_port_arbiter_tag_fifo
  import mem_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  arb_owner_e    push_owner,
  input  logic          pop,
  input  logic          kill_fetch,
  output arb_tag_s      head,
  output logic [CW-1:0] count
);
  arb_tag_s ent [DEPTH];
  logic [PW-1:0] wptr, rptr;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign head = ent[rptr];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) ent[i] <= '{ARB_OWN_I, 1'b0};
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (kill_fetch && ent[i].owner == ARB_OWN_I) ent[i].kill <= 1'b1;
      // the pushed slot is always free, so a fresh tag is never killed by this cycle's flush
      if (push) begin
        ent[wptr] <= '{push_owner, 1'b0};
        wptr      <= inc(wptr);
      end
      if (pop) rptr <= inc(rptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data, routing in-order responses
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_OUT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        if_flush,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        err_orphan
);
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] count;
  logic [SW-1:0] starve;
  arb_tag_s      head;
  logic          room, can_issue, win_d, win_i, pop, stale;
  assign room      = count < CW'(MAX_OUT);
  assign can_issue = mem_ready && room;
  assign win_d     = d_req && !(if_req && starve == SW'(STARVE_MAX));
  assign win_i     = !win_d && if_req;
  // outputs are forced low while reset is held, not just after it
  assign d_gnt     = reset && win_d && can_issue;
  assign if_gnt    = reset && win_i && can_issue;
  assign mem_req   = reset && (if_req || d_req) && room;
  assign mem_we    = reset && win_d && d_we;
  assign mem_addr  = !reset ? '0 : win_d ? d_addr : if_addr;
  assign mem_wdata = reset && win_d ? d_wdata : '0;
  assign mem_be    = !reset ? '0 : win_d ? d_be : 4'hF;
  assign pop       = mem_rvalid && count != '0;
  assign stale     = head.kill || (if_flush && head.owner == ARB_OWN_I);
  assign if_rvalid = reset && pop && head.owner == ARB_OWN_I && !stale;
  assign d_rvalid  = reset && pop && head.owner == ARB_OWN_D;
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = d_rvalid ? mem_rdata : '0;
  mem_port_arbiter_tag_fifo #(.DEPTH(MAX_OUT)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (if_gnt || d_gnt),
    .push_owner (d_gnt ? ARB_OWN_D : ARB_OWN_I),
    .pop        (pop),
    .kill_fetch (if_flush),
    .head       (head),
    .count      (count)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve     <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (!if_req || if_gnt) starve <= '0;
      else if (d_gnt && starve != SW'(STARVE_MAX)) starve <= starve + 1'b1;
      if (mem_rvalid && count == '0) err_orphan <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random checks of mem_port_arbiter against a queue-based model
module tb_mem_port_arbiter;
  localparam int MAX_OUT = 2, STARVE_MAX = 4;
  logic clk = 1'b0, reset;
  logic if_req, if_gnt, if_rvalid, if_flush, d_req, d_we, d_gnt, d_rvalid;
  logic mem_req, mem_we, mem_ready, mem_rvalid, err_orphan;
  logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0] d_be, mem_be;
  int n_assert = 0, n_fail = 0;
  typedef struct {bit d; bit stale;} ent_t;
  ent_t q[$];
  int lost = 0;
  bit orphan = 0, last_ig = 0, last_dg = 0;
  logic o_ignt, o_dgnt, o_irv, o_drv, o_mreq, o_mwe;
  logic [31:0] o_irdata, o_drdata;
  logic [3:0] o_mbe;

  mem_port_arbiter #(.MAX_OUT(MAX_OUT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_flush(if_flush), .d_req(d_req), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    if_req = 0; if_addr = 0; if_flush = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    d_be = 0; mem_ready = 1; mem_rvalid = 0; mem_rdata = 0;
  endtask

  task automatic chk_reset_outputs();
    @(negedge clk);
    chk("rst_if_gnt", 32'(if_gnt), 0);       chk("rst_d_gnt", 32'(d_gnt), 0);
    chk("rst_if_rvalid", 32'(if_rvalid), 0); chk("rst_d_rvalid", 32'(d_rvalid), 0);
    chk("rst_if_rdata", if_rdata, 0);        chk("rst_d_rdata", d_rdata, 0);
    chk("rst_mem_req", 32'(mem_req), 0);     chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", mem_addr, 0);        chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_be", 32'(mem_be), 0);       chk("rst_err_orphan", 32'(err_orphan), 0);
    @(posedge clk); #1;
  endtask

  // One clock: predict outputs from the model, compare at negedge, then advance the model.
  task automatic cycle();
    bit can, dwin, ei, ed, em, eirv, edrv, st;
    ent_t h;
    @(negedge clk);
    can  = mem_ready && q.size() < MAX_OUT;
    dwin = d_req && !(if_req && lost == STARVE_MAX);
    ed   = dwin && can;
    ei   = !dwin && if_req && can;
    em   = (if_req || d_req) && q.size() < MAX_OUT;
    eirv = 0; edrv = 0;
    if (mem_rvalid && q.size() > 0) begin
      h = q[0];
      st = h.stale || (if_flush && !h.d);
      eirv = !h.d && !st;
      edrv = h.d;
    end
    o_ignt = if_gnt; o_dgnt = d_gnt; o_irv = if_rvalid; o_drv = d_rvalid; o_mreq = mem_req;
    o_irdata = if_rdata; o_drdata = d_rdata; o_mwe = mem_we; o_mbe = mem_be;
    chk("if_gnt", 32'(if_gnt), 32'(ei));
    chk("d_gnt", 32'(d_gnt), 32'(ed));
    chk("mem_req", 32'(mem_req), 32'(em));
    chk("if_rvalid", 32'(if_rvalid), 32'(eirv));
    chk("d_rvalid", 32'(d_rvalid), 32'(edrv));
    chk("if_rdata", if_rdata, eirv ? mem_rdata : 32'h0);
    if (edrv && !d_we) chk("d_rdata", d_rdata, mem_rdata);
    chk("err_orphan", 32'(err_orphan), 32'(orphan));
    if (em) begin
      chk("mem_addr", mem_addr, dwin ? d_addr : if_addr);
      chk("mem_we", 32'(mem_we), dwin ? 32'(d_we) : 0);
      chk("mem_be", 32'(mem_be), dwin ? 32'(d_be) : 32'hF);
      chk("mem_wdata", mem_wdata, dwin ? d_wdata : 32'h0);
    end
    if (if_flush) foreach (q[i]) if (!q[i].d) q[i].stale = 1;
    if (mem_rvalid) begin
      if (q.size() > 0) void'(q.pop_front());
      else orphan = 1;
    end
    if (ei || ed) q.push_back('{ed, 1'b0});
    lost = (!if_req || ei) ? 0 : (ed && lost < STARVE_MAX) ? lost + 1 : lost;
    last_ig = ei; last_dg = ed;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    if_req = 0; d_req = 0; if_flush = 0;
    for (int g = 0; g < 8 && q.size() > 0; g++) begin
      mem_rvalid = 1; mem_rdata = $urandom; cycle();
    end
    mem_rvalid = 0;
  endtask

  initial begin
    reset = 0;
    idle_inputs();
    if_req = 1; d_req = 1; d_we = 1; d_be = 4'hF; mem_rvalid = 1; mem_rdata = 32'h55;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs();
    idle_inputs();
    reset = 1;
    cycle();
    // single fetch, response two cycles after grant
    if_req = 1; if_addr = 32'h100; cycle(); chk("t1_gnt", 32'(o_ignt), 1);
    if_req = 0; cycle(); chk("t1_early", 32'(o_irv), 0);
    mem_rvalid = 1; mem_rdata = 32'hDEADBEEF; cycle();
    chk("t1_rvalid", 32'(o_irv), 1); chk("t1_rdata", o_irdata, 32'hDEADBEEF);
    mem_rvalid = 0; cycle();
    // starvation: data wins four times, then fetch forced
    if_req = 1; if_addr = 32'h200; d_req = 1; d_we = 0; d_addr = 32'h2000;
    for (int k = 0; k < 6; k++) begin
      mem_rvalid = k > 0; mem_rdata = $urandom; cycle();
      chk("starve_d", 32'(o_dgnt), 32'(k != 4));
      chk("starve_i", 32'(o_ignt), 32'(k == 4));
    end
    drain();
    // fetch, store, fetch in order
    if_req = 1; if_addr = 32'h500; cycle(); chk("t3_f0", 32'(o_ignt), 1);
    if_req = 0; d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'h12345678; d_be = 4'b0011;
    cycle(); chk("t3_st", 32'(o_dgnt), 1); chk("t3_be", 32'(o_mbe), 3); chk("t3_we", 32'(o_mwe), 1);
    d_req = 0; d_we = 0; if_req = 1; if_addr = 32'h504; mem_rvalid = 1; mem_rdata = 32'hA1;
    cycle(); chk("t3_r0", 32'(o_irv), 1); chk("t3_full", 32'(o_ignt), 0); chk("t3_mreq", 32'(o_mreq), 0);
    mem_rdata = 32'hA2; cycle(); chk("t3_r1", 32'(o_drv), 1); chk("t3_f1", 32'(o_ignt), 1);
    if_req = 0; mem_rdata = 32'hA3; cycle(); chk("t3_r2", 32'(o_irv), 1); chk("t3_r2d", o_irdata, 32'hA3);
    mem_rvalid = 0; cycle();
    // flush with two stale fetches in flight
    if_req = 1; if_addr = 32'h600; cycle();
    if_addr = 32'h604; cycle();
    if_addr = 32'h300; if_flush = 1; mem_rvalid = 1; cycle();
    chk("t4_stale0", 32'(o_irv), 0); chk("t4_blk", 32'(o_ignt), 0);
    if_flush = 0; cycle(); chk("t4_stale1", 32'(o_irv), 0); chk("t4_gnt", 32'(o_ignt), 1);
    if_req = 0; mem_rdata = 32'h300C0DE; cycle();
    chk("t4_new", 32'(o_irv), 1); chk("t4_newd", o_irdata, 32'h300C0DE);
    mem_rvalid = 0;
    // fetch granted in the flush cycle survives
    if_req = 1; if_addr = 32'h700; cycle();
    if_addr = 32'h800; if_flush = 1; cycle(); chk("t4b_gnt", 32'(o_ignt), 1);
    if_flush = 0; if_req = 0; mem_rvalid = 1; cycle(); chk("t4b_old", 32'(o_irv), 0);
    cycle(); chk("t4b_new", 32'(o_irv), 1);
    mem_rvalid = 0;
    // fill to MAX_OUT, no pass-through on pop
    if_req = 1; if_addr = 32'h900; cycle();
    if_req = 0; d_req = 1; d_we = 0; d_addr = 32'h3000; cycle();
    d_req = 0; if_req = 1; if_addr = 32'h904; cycle();
    chk("t5_mreq", 32'(o_mreq), 0); chk("t5_gnt", 32'(o_ignt), 0);
    mem_rvalid = 1; cycle(); chk("t5_popblk", 32'(o_ignt), 0); chk("t5_rv", 32'(o_irv), 1);
    mem_rvalid = 0; cycle(); chk("t5_after", 32'(o_ignt), 1);
    drain();
    // random traffic
    for (int k = 0; k < 400; k++) begin
      if (!if_req || last_ig) begin if_req = $urandom_range(2) != 0; if_addr = $urandom & ~32'h3; end
      if (!d_req || last_dg) begin
        d_req = $urandom_range(1) != 0; d_we = $urandom_range(1) != 0; d_addr = $urandom;
        d_wdata = $urandom; d_be = 4'($urandom_range(15));
      end
      if_flush = $urandom_range(7) == 0;
      mem_ready = $urandom_range(3) != 0;
      mem_rvalid = q.size() > 0 && $urandom_range(1) != 0;
      mem_rdata = $urandom;
      cycle();
    end
    mem_ready = 1;
    drain();
    // orphan response, sticky until reset
    mem_rvalid = 1; mem_rdata = 32'h77; cycle();
    chk("t6_irv", 32'(o_irv), 0); chk("t6_drv", 32'(o_drv), 0);
    mem_rvalid = 0; cycle(); cycle();
    if_req = 1; d_req = 1; mem_rvalid = 1;
    reset = 0;
    chk_reset_outputs();
    idle_inputs(); reset = 1; q.delete(); lost = 0; orphan = 0;
    cycle();
    // reset with a request in flight: its late response is an orphan
    if_req = 1; if_addr = 32'hA00; cycle();
    if_req = 0; reset = 0;
    chk_reset_outputs();
    reset = 1; q.delete(); lost = 0; orphan = 0;
    mem_rvalid = 1; cycle(); chk("t7_irv", 32'(o_irv), 0);
    mem_rvalid = 0; cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
